lsm_sequencer: RTL and testbench
================================

// Module: lsm_sequencer
// PURPOSE
//   Load/store-multiple (LDM/STM) sequencer that drives the register bank's Rd select and latch/gate controls.
//   Walks the 16-bit register list of an ARMv4 block-transfer instruction, lowest register first.
//   Issues one memory word access per listed register and optionally writes back the updated base.
//   Sits between the control unit and the register bank; the register bank is the responder on LSM_RD and latch/gate.
// PARAMETERS
//   ADDR_W      32  width of BASE, MEM_ADDR and WB_DATA
//   WORD_BYTES  4   address stride per transferred register
// PORTS
//   clk         in   1       system clock; all state updates on posedge
//   rst_n       in   1       asynchronous reset, active-low
//   START       in   1       one-cycle request; samples IR and BASE when the block is idle
//   IR          in   32      instruction: [15:0] reglist, [20] L (1=LDM), [21] W, [23] U, [24] P
//   BASE        in   ADDR_W  Rn value read from the register bank (A_BUS)
//   MEM_ACK     in   1       memory completes the current access this cycle
//   LSM_RD      out  4       register index presented to the register bank Rd/Rs select
//   LSM_RD_MUX  out  1       1 = register bank uses LSM_RD instead of the IR fields
//   REG_GATE_C  out  1       STM: register bank drives LSM_RD onto C_BUS (store data)
//   LATCH_REG   out  1       LDM: register bank latches load data into LSM_RD at this edge
//   MEM_REQ     out  1       memory access valid
//   MEM_WE      out  1       1 = store (STM), 0 = load (LDM)
//   MEM_ADDR    out  ADDR_W  word address of the current access
//   WB_EN       out  1       base writeback strobe (one cycle); Rd = IR[19:16]
//   WB_DATA     out  ADDR_W  written-back base value
//   BUSY        out  1       high from the cycle after START until DONE
//   DONE        out  1       one-cycle completion pulse
// BEHAVIOUR
//   Reset: state IDLE, mask = 0, every output 0 (including LSM_RD, MEM_ADDR, WB_DATA). Reset mid-op aborts
//     immediately with no further REQ, latch or writeback.
//   Sampling at START: n = popcount(reglist), 0..16. Start address is fixed by P/U:
//     IA (P0 U1) base; IB (P1 U1) base+4; DA (P0 U0) base-4n+4; DB (P1 U0) base-4n.
//     Final base: U ? base+4n : base-4n. All arithmetic is modulo 2^ADDR_W.
//   States:
//     IDLE: START=1 and n>0 -> XFER; START=1 and n=0 -> DONE (no REQ, no WB).
//     XFER: MEM_REQ=1, LSM_RD_MUX=1, LSM_RD = lowest set bit of mask, MEM_WE = ~L, REG_GATE_C = ~L.
//       LATCH_REG = L & MEM_ACK (combinational).
//       MEM_ACK=0: every output held stable.
//       MEM_ACK=1: clear that mask bit and add WORD_BYTES to the address. If the mask becomes empty,
//         go to WB when W=1, otherwise to DONE.
//     WB: WB_EN=1 and WB_DATA = final base for 1 cycle -> DONE.
//     DONE: DONE=1 for 1 cycle, BUSY=0 -> IDLE.
//   Latency: with zero-wait memory (ACK tied high), first REQ is in the cycle after START.
//     DONE arrives n+1 cycles after START, or n+2 cycles when W=1.
//   START while BUSY or in DONE: ignored. START in the IDLE cycle directly after DONE: accepted.
//   R15 in the list is transferred last (address order). An LDM writing R15 raises LATCH_REG only;
//     PC-update semantics belong to the register bank.
//   LDM with W=1 and Rn in the list: the WB value overwrites the loaded value (WB follows the last latch).
// TESTING
//   1 STMIA, list {R0,R2,R5}, BASE=0x1000, ACK=1: LSM_RD 0,2,5; MEM_ADDR 0x1000,0x1004,0x1008; MEM_WE=1;
//     REG_GATE_C=1 in those 3 cycles; no WB_EN; DONE 4 cycles after START.
//   2 LDMDB W=1, list {R1,R14}, BASE=0x2000: MEM_ADDR 0x1FF8 (R1), 0x1FFC (R14); LATCH_REG on each ACK;
//     WB_EN with WB_DATA=0x1FF8; DONE at cycle 4.
//   3 LDMIB, list {R3}, BASE=0x100, ACK low for 2 cycles: MEM_ADDR=0x104 and LSM_RD=3 held 3 cycles;
//     LATCH_REG only in the ACK cycle.
//   4 Empty list (IR[15:0]=0): DONE the cycle after START; MEM_REQ and WB_EN never asserted.
//   5 STMDA, list 0xFFFF, BASE=0x8000: 16 accesses 0x7FC4..0x8000, R15 last; a second START mid-transfer
//     is ignored; rst_n pulsed low at access 8 drops all outputs to 0 asynchronously.

Source files
------------

// File: rtl/lsm_sequencer_if.sv
// Handshake bundle between the control unit, the LDM/STM sequencer and the register bank / memory.
// master: the sequencer (consumes START/IR/BASE/MEM_ACK, drives register-select, memory and status outputs).
// slave:  the environment (control unit + register bank + memory) driving the request side.
interface lsm_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              START;
   logic [31:0]       IR;
   logic [ADDR_W-1:0] BASE;
   logic              MEM_ACK;
   logic [3:0]        LSM_RD;
   logic              LSM_RD_MUX;
   logic              REG_GATE_C;
   logic              LATCH_REG;
   logic              MEM_REQ;
   logic              MEM_WE;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic              WB_EN;
   logic [ADDR_W-1:0] WB_DATA;
   logic              BUSY;
   logic              DONE;

   modport master (
      input  START, IR, BASE, MEM_ACK,
      output LSM_RD, LSM_RD_MUX, REG_GATE_C, LATCH_REG, MEM_REQ, MEM_WE,
             MEM_ADDR, WB_EN, WB_DATA, BUSY, DONE
   );

   modport slave (
      output START, IR, BASE, MEM_ACK,
      input  LSM_RD, LSM_RD_MUX, REG_GATE_C, LATCH_REG, MEM_REQ, MEM_WE,
             MEM_ADDR, WB_EN, WB_DATA, BUSY, DONE
   );
endinterface

// File: rtl/lsm_sequencer.sv
// Purpose: ARMv4 LDM/STM sequencer; walks the register list lowest-first, one word access per register, optional base writeback.
// Latency: first MEM_REQ the cycle after START; DONE n+1 cycles after START (n+2 with writeback) under zero-wait memory.
// Backpressure: MEM_ACK low stalls the current access with every output held; START outside IDLE is ignored.
// Ports: clk, rst_n (async active-low); bus.master carries START/IR/BASE/MEM_ACK in and
//   LSM_RD/LSM_RD_MUX/REG_GATE_C/LATCH_REG/MEM_REQ/MEM_WE/MEM_ADDR/WB_EN/WB_DATA/BUSY/DONE out.
module lsm_sequencer #(
   parameter int ADDR_W     = 32,
   parameter int WORD_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   lsm_sequencer_if.master   bus
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

   state_t            state;
   logic [15:0]       mask;
   logic              load_q;
   logic              wb_q;
   logic [ADDR_W-1:0] final_base;

   logic [15:0]       reglist;
   logic [4:0]        n_regs;
   logic [ADDR_W-1:0] stride;
   logic [ADDR_W-1:0] span;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_base;
   logic [15:0]       mask_next;
   logic              unused_ir;

   // Rd (IR[19:16]) is applied by the register bank alongside WB_EN; S and condition bits are not ours.
   assign unused_ir = ^{bus.IR[31:25], bus.IR[22], bus.IR[19:16]};

   function automatic logic [3:0] lowest_set(input logic [15:0] m);
      lowest_set = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i]) lowest_set = 4'(i);
      end
   endfunction

   assign reglist   = bus.IR[15:0];
   assign stride    = ADDR_W'(WORD_BYTES);
   // Clearing the lowest set bit is the same as retiring the register currently on LSM_RD.
   assign mask_next = mask & (mask - 16'd1);

   always_comb begin
      n_regs = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n_regs = n_regs + 5'(reglist[i]);
      end
      span = ADDR_W'(n_regs) * stride;
      // The block always ascends in memory; P/U only pick where the lowest address sits.
      case ({bus.IR[24], bus.IR[23]})
         2'b01:   start_addr = bus.BASE;
         2'b11:   start_addr = bus.BASE + stride;
         2'b00:   start_addr = bus.BASE - span + stride;
         default: start_addr = bus.BASE - span;
      endcase
      end_base = bus.IR[23] ? (bus.BASE + span) : (bus.BASE - span);
   end

   // Combinational so the register bank captures load data on the very edge the memory acks.
   assign bus.LATCH_REG = (state == S_XFER) & load_q & bus.MEM_ACK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         mask           <= 16'd0;
         load_q         <= 1'b0;
         wb_q           <= 1'b0;
         final_base     <= '0;
         bus.LSM_RD     <= 4'd0;
         bus.LSM_RD_MUX <= 1'b0;
         bus.REG_GATE_C <= 1'b0;
         bus.MEM_REQ    <= 1'b0;
         bus.MEM_WE     <= 1'b0;
         bus.MEM_ADDR   <= '0;
         bus.WB_EN      <= 1'b0;
         bus.WB_DATA    <= '0;
         bus.BUSY       <= 1'b0;
         bus.DONE       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               bus.DONE <= 1'b0;
               if (bus.START) begin
                  mask       <= reglist;
                  load_q     <= bus.IR[20];
                  wb_q       <= bus.IR[21];
                  final_base <= end_base;
                  if (n_regs != 5'd0) begin
                     state          <= S_XFER;
                     bus.BUSY       <= 1'b1;
                     bus.MEM_REQ    <= 1'b1;
                     bus.LSM_RD_MUX <= 1'b1;
                     bus.LSM_RD     <= lowest_set(reglist);
                     bus.MEM_WE     <= ~bus.IR[20];
                     bus.REG_GATE_C <= ~bus.IR[20];
                     bus.MEM_ADDR   <= start_addr;
                  end else begin
                     // Empty list: nothing to transfer and no writeback.
                     state    <= S_DONE;
                     bus.DONE <= 1'b1;
                  end
               end
            end

            S_XFER: begin
               if (bus.MEM_ACK) begin
                  mask <= mask_next;
                  if (mask_next != 16'd0) begin
                     bus.LSM_RD   <= lowest_set(mask_next);
                     bus.MEM_ADDR <= bus.MEM_ADDR + stride;
                  end else begin
                     bus.MEM_REQ    <= 1'b0;
                     bus.LSM_RD_MUX <= 1'b0;
                     bus.LSM_RD     <= 4'd0;
                     bus.MEM_WE     <= 1'b0;
                     bus.REG_GATE_C <= 1'b0;
                     bus.MEM_ADDR   <= '0;
                     if (wb_q) begin
                        state       <= S_WB;
                        bus.WB_EN   <= 1'b1;
                        bus.WB_DATA <= final_base;
                     end else begin
                        state    <= S_DONE;
                        bus.BUSY <= 1'b0;
                        bus.DONE <= 1'b1;
                     end
                  end
               end
            end

            S_WB: begin
               state       <= S_DONE;
               bus.WB_EN   <= 1'b0;
               bus.WB_DATA <= '0;
               bus.BUSY    <= 1'b0;
               bus.DONE    <= 1'b1;
            end

            default: begin
               state    <= S_IDLE;
               bus.DONE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Bench for lsm_sequencer: directed vector table plus randomized operations against a list-based model.
module tb_lsm_sequencer;

   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsm_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   lsm_sequencer #(.ADDR_W(ADDR_W), .WORD_BYTES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] ir;
      logic [31:0] base;
      int          mode;       // 0 ack high, 1 ack low in cycles 1-2, 2 random ack
      int          start_mid;  // cycle to pulse a stray START (0 = none)
      bit          idle_chk;
      logic [31:0] exp_first;
      int          exp_done;
      logic [31:0] exp_wb;
   } vec_t;

   // Runs one block transfer and checks every cycle against a model derived from the reglist.
   task automatic run_op(input logic [31:0] ir, input logic [31:0] base, input int mode,
                         input int start_mid, input bit idle_chk,
                         output logic [31:0] first_addr, output int done_cyc, output logic [31:0] wb_val);
      logic [255:0] ack_pat;
      logic [3:0]   e_rd [16];
      logic [31:0]  e_addr [16];
      int           e_cyc [16];
      logic [31:0]  start, fin;
      logic         L, W, U, P;
      int           n, k, c, e_done, nacc, nwb, wb_cyc;
      logic         prev_stall;
      logic [3:0]   prev_rd;
      logic [31:0]  prev_addr;

      for (int i = 0; i < 256; i++) begin
         case (mode)
            0:       ack_pat[i] = 1'b1;
            1:       ack_pat[i] = !(i == 1 || i == 2);
            default: ack_pat[i] = ($urandom_range(0, 2) != 0);
         endcase
      end

      L = ir[20]; W = ir[21]; U = ir[23]; P = ir[24];
      n = 0;
      for (int r = 0; r < 16; r++) begin
         if (ir[r]) begin
            e_rd[n] = 4'(r);
            n++;
         end
      end
      if (!P && U)      start = base;
      else if (P && U)  start = base + 32'd4;
      else if (!P)      start = base - 32'(4 * n) + 32'd4;
      else              start = base - 32'(4 * n);
      fin = U ? base + 32'(4 * n) : base - 32'(4 * n);
      for (int i = 0; i < n; i++) e_addr[i] = start + 32'(4 * i);
      c = 1; k = 0;
      while (k < n && c < 250) begin
         if (ack_pat[c]) begin
            e_cyc[k] = c;
            k++;
         end
         c++;
      end
      e_done = (n == 0) ? 1 : c + (W ? 1 : 0);

      @(posedge clk); #1;
      bus.START = 1'b1; bus.IR = ir; bus.BASE = base; bus.MEM_ACK = 1'b0;
      @(posedge clk); #1;
      bus.START = 1'b0;
      nacc = 0; nwb = 0; done_cyc = -1; wb_cyc = -1; prev_stall = 1'b0;
      prev_rd = 4'd0; prev_addr = 32'd0; first_addr = 32'd0; wb_val = 32'd0;

      for (int cyc = 1; cyc <= 200; cyc++) begin
         bus.MEM_ACK = ack_pat[cyc];
         if (cyc == start_mid) begin
            bus.START = 1'b1; bus.IR = 32'h0080_0001; bus.BASE = 32'hDEAD_0000;
         end else begin
            bus.START = 1'b0; bus.IR = ir; bus.BASE = base;
         end
         @(negedge clk);
         if (bus.MEM_REQ) begin
            if (prev_stall) begin
               chk("hold_rd", bus.LSM_RD, prev_rd);
               chk("hold_addr", bus.MEM_ADDR, prev_addr);
            end
            chk("latch", bus.LATCH_REG, L & ack_pat[cyc]);
            if (ack_pat[cyc]) begin
               if (nacc < n) begin
                  chk("acc_rd", bus.LSM_RD, e_rd[nacc]);
                  chk("acc_addr", bus.MEM_ADDR, e_addr[nacc]);
                  chk("acc_cycle", cyc, e_cyc[nacc]);
                  chk("acc_we_gate_mux", {bus.MEM_WE, bus.REG_GATE_C, bus.LSM_RD_MUX}, {~L, ~L, 1'b1});
               end else begin
                  chk("extra_access", nacc + 1, n);
               end
               if (nacc == 0) first_addr = bus.MEM_ADDR;
               nacc++;
            end
            prev_stall = !ack_pat[cyc];
            prev_rd    = bus.LSM_RD;
            prev_addr  = bus.MEM_ADDR;
         end else begin
            chk("latch_no_req", bus.LATCH_REG, 1'b0);
            prev_stall = 1'b0;
         end
         if (bus.WB_EN) begin
            nwb++;
            wb_val = bus.WB_DATA;
            wb_cyc = cyc;
         end
         chk("busy", bus.BUSY, cyc < e_done);
         if (bus.DONE) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      bus.START = 1'b0;
      bus.MEM_ACK = 1'b0;

      if (done_cyc < 0) chk("done_timeout", done_cyc, e_done);
      chk("n_access", nacc, n);
      chk("done_cycle", done_cyc, e_done);
      chk("wb_count", nwb, (W && n > 0) ? 1 : 0);
      if (W && n > 0) begin
         chk("wb_data", wb_val, fin);
         chk("wb_cycle", wb_cyc, e_done - 1);
      end
      if (idle_chk) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("idle_req_busy", {bus.MEM_REQ, bus.BUSY, bus.DONE}, 3'b000);
      end
   endtask

   vec_t        vecs [8];
   logic [31:0] got_first, got_wb;
   int          got_done;
   int          acc_cnt;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //             ir            base          mode mid idle first         done wb
      vecs[0] = '{32'h0080_0025, 32'h0000_1000, 0,   0,  0, 32'h0000_1000, 4,  32'h0};
      vecs[1] = '{32'h0130_4002, 32'h0000_2000, 0,   0,  0, 32'h0000_1FF8, 4,  32'h0000_1FF8};
      vecs[2] = '{32'h0190_0008, 32'h0000_0100, 1,   0,  0, 32'h0000_0104, 4,  32'h0};
      vecs[3] = '{32'h0080_0000, 32'h0000_0040, 0,   0,  1, 32'h0,         1,  32'h0};
      vecs[4] = '{32'h00A0_0000, 32'h0000_0040, 0,   0,  0, 32'h0,         1,  32'h0};
      vecs[5] = '{32'h0000_FFFF, 32'h0000_8000, 0,   5,  1, 32'h0000_7FC4, 17, 32'h0};
      vecs[6] = '{32'h00B0_8001, 32'hFFFF_FFFC, 0,   0,  0, 32'hFFFF_FFFC, 4,  32'h0000_0004};
      vecs[7] = '{32'h01A0_8000, 32'h0000_0000, 0,   3,  1, 32'h0000_0004, 3,  32'h0000_0004};

      bus.START = 1'b0; bus.IR = 32'h0; bus.BASE = 32'h0; bus.MEM_ACK = 1'b0;
      rst_n = 1'b0;
      #12;
      chk("reset_ctrl", {bus.LSM_RD, bus.LSM_RD_MUX, bus.REG_GATE_C, bus.LATCH_REG, bus.MEM_REQ,
                         bus.MEM_WE, bus.WB_EN, bus.BUSY, bus.DONE}, 12'h0);
      chk("reset_addr_wb", {bus.MEM_ADDR, bus.WB_DATA}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 8; v++) begin
         run_op(vecs[v].ir, vecs[v].base, vecs[v].mode, vecs[v].start_mid, vecs[v].idle_chk,
                got_first, got_done, got_wb);
         if (vecs[v].ir[15:0] != 16'h0) chk($sformatf("vec%0d_first_addr", v), got_first, vecs[v].exp_first);
         chk($sformatf("vec%0d_done", v), got_done, vecs[v].exp_done);
         if (vecs[v].ir[21] && vecs[v].ir[15:0] != 16'h0) chk($sformatf("vec%0d_wb", v), got_wb, vecs[v].exp_wb);
      end

      // Asynchronous reset in the middle of a 16-register STMDA.
      bus.IR = 32'h0000_FFFF; bus.BASE = 32'h0000_8000;
      @(posedge clk); #1;
      bus.START = 1'b1;
      @(posedge clk); #1;
      bus.START = 1'b0; bus.MEM_ACK = 1'b1;
      acc_cnt = 0;
      for (int i = 0; i < 40 && acc_cnt < 8; i++) begin
         @(negedge clk);
         if (bus.MEM_REQ) acc_cnt++;
      end
      chk("rst_access_count", acc_cnt, 8);
      chk("pre_rst_addr", bus.MEM_ADDR, 32'h0000_7FE0);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", {bus.LSM_RD, bus.LSM_RD_MUX, bus.REG_GATE_C, bus.LATCH_REG, bus.MEM_REQ,
                          bus.MEM_WE, bus.WB_EN, bus.BUSY, bus.DONE}, 12'h0);
      chk("midrst_addr_wb", {bus.MEM_ADDR, bus.WB_DATA}, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", {bus.MEM_REQ, bus.LATCH_REG, bus.WB_EN, bus.BUSY, bus.DONE}, 5'b0);
      end
      bus.MEM_ACK = 1'b0;

      // Random operations with random memory wait states.
      for (int t = 0; t < 25; t++) begin
         logic [31:0] rir;
         rir = $urandom;
         rir[15:0] = (t % 6 == 5) ? 16'h0 : 16'($urandom & $urandom);
         run_op(rir, $urandom, 2, 0, 1'b0, got_first, got_done, got_wb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
